// File: rtl/issue_pipe.sv
// Multi-lane registered issue stage: per-lane operand read with CDB bypass,
// held in a two-entry (main + skid) buffer so EX back-pressure never reaches select combinationally.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 5
`endif

package issue_pipe_pkg;
  localparam int XLEN   = `XLEN;
  localparam int PREG_W = `PHYS_REG_IDX_SZ + 1;

  typedef struct packed {
    logic [PREG_W-1:0] reg_num;
  } REG_TAG;

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] NPC;
    logic [1:0]      opa_select;
    logic [1:0]      opb_select;
    logic [4:0]      alu_func;
    logic            rd_mem;
    logic            wr_mem;
    logic            cond_branch;
    logic            uncond_branch;
    logic            halt;
    logic            illegal;
    logic            csr_op;
    logic [2:0]      function_type;
    logic [4:0]      rob_index;
    logic            has_dest;
    logic [1:0]      issued_fu_index;
    REG_TAG          src1_reg;
    REG_TAG          src2_reg;
    REG_TAG          dest_reg;
  } ID_IS_PACKET;

  typedef struct packed {
    logic              valid;
    logic [31:0]       inst;
    logic [XLEN-1:0]   PC;
    logic [XLEN-1:0]   NPC;
    logic [1:0]        opa_select;
    logic [1:0]        opb_select;
    logic [4:0]        alu_func;
    logic              rd_mem;
    logic              wr_mem;
    logic              cond_branch;
    logic              uncond_branch;
    logic              halt;
    logic              illegal;
    logic              csr_op;
    logic [2:0]        function_type;
    logic [4:0]        rob_index;
    logic              has_dest;
    logic [1:0]        issued_fu_index;
    logic [PREG_W-1:0] dest_reg_idx;
    logic [XLEN-1:0]   rs1_value;
    logic [XLEN-1:0]   rs2_value;
  } IS_EX_PACKET;
endpackage

module issue_pipe
  import issue_pipe_pkg::*;
#(
  parameter int ISSUE_WIDTH = 2,
  parameter int CDB_WIDTH   = 2
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  ID_IS_PACKET [ISSUE_WIDTH-1:0]                 id_is_packet,
  output logic        [ISSUE_WIDTH-1:0]                 is_ready,
  output logic        [ISSUE_WIDTH-1:0][`PHYS_REG_IDX_SZ:0] rs1_preg_idx,
  output logic        [ISSUE_WIDTH-1:0][`PHYS_REG_IDX_SZ:0] rs2_preg_idx,
  input  logic        [ISSUE_WIDTH-1:0][`XLEN-1:0]      rs1_preg_data,
  input  logic        [ISSUE_WIDTH-1:0][`XLEN-1:0]      rs2_preg_data,
  input  logic        [CDB_WIDTH-1:0]                   cdb_valid,
  input  logic        [CDB_WIDTH-1:0][`PHYS_REG_IDX_SZ:0]   cdb_preg_idx,
  input  logic        [CDB_WIDTH-1:0][`XLEN-1:0]        cdb_value,
  input  logic                                          squash,
  input  logic        [ISSUE_WIDTH-1:0]                 ex_ready,
  output IS_EX_PACKET [ISSUE_WIDTH-1:0]                 is_ex_packet
);

  IS_EX_PACKET [ISSUE_WIDTH-1:0] main_q, main_d;
  IS_EX_PACKET [ISSUE_WIDTH-1:0] skid_q, skid_d;
  IS_EX_PACKET [ISSUE_WIDTH-1:0] cap;
  logic        [ISSUE_WIDTH-1:0] accept;

  // Regfile does not forward same-edge writes, so the lowest matching CDB port overrides it.
  function automatic logic [XLEN-1:0] bypass(
    input logic [PREG_W-1:0]                  idx,
    input logic [XLEN-1:0]                    rf_data,
    input logic [CDB_WIDTH-1:0]               bv,
    input logic [CDB_WIDTH-1:0][PREG_W-1:0]   btag,
    input logic [CDB_WIDTH-1:0][XLEN-1:0]     bval
  );
    logic [XLEN-1:0] sel;
    sel = rf_data;
    for (int c = CDB_WIDTH - 1; c >= 0; c--) begin
      if (bv[c] && (btag[c] == idx)) sel = bval[c];
    end
    return sel;
  endfunction

  function automatic IS_EX_PACKET capture(
    input ID_IS_PACKET     pin,
    input logic [XLEN-1:0] op1,
    input logic [XLEN-1:0] op2
  );
    IS_EX_PACKET p;
    p                 = '0;
    p.valid           = 1'b1;
    p.inst            = pin.inst;
    p.PC              = pin.PC;
    p.NPC             = pin.NPC;
    p.opa_select      = pin.opa_select;
    p.opb_select      = pin.opb_select;
    p.alu_func        = pin.alu_func;
    p.rd_mem          = pin.rd_mem;
    p.wr_mem          = pin.wr_mem;
    p.cond_branch     = pin.cond_branch;
    p.uncond_branch   = pin.uncond_branch;
    p.halt            = pin.halt;
    p.illegal         = pin.illegal;
    p.csr_op          = pin.csr_op;
    p.function_type   = pin.function_type;
    p.rob_index       = pin.rob_index;
    p.has_dest        = pin.has_dest;
    p.issued_fu_index = pin.issued_fu_index;
    p.dest_reg_idx    = pin.dest_reg.reg_num;
    p.rs1_value       = op1;
    p.rs2_value       = op2;
    return p;
  endfunction

  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      rs1_preg_idx[i] = id_is_packet[i].src1_reg.reg_num;
      rs2_preg_idx[i] = id_is_packet[i].src2_reg.reg_num;
      is_ready[i]     = ~skid_q[i].valid;
    end
  end

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    accept = '0;
    cap    = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      accept[i] = id_is_packet[i].valid && !skid_q[i].valid && !squash;
      cap[i]    = capture(id_is_packet[i],
                          bypass(id_is_packet[i].src1_reg.reg_num, rs1_preg_data[i],
                                 cdb_valid, cdb_preg_idx, cdb_value),
                          bypass(id_is_packet[i].src2_reg.reg_num, rs2_preg_data[i],
                                 cdb_valid, cdb_preg_idx, cdb_value));
      // Only valid bits change on squash/drain; payload keeps its last value.
      if (squash) begin
        main_d[i].valid = 1'b0;
        skid_d[i].valid = 1'b0;
      end else if (!main_q[i].valid) begin
        if (accept[i]) main_d[i] = cap[i];
      end else if (!skid_q[i].valid) begin
        if (ex_ready[i]) begin
          if (accept[i]) main_d[i] = cap[i];
          else           main_d[i].valid = 1'b0;
        end else if (accept[i]) begin
          skid_d[i] = cap[i];
        end
      end else if (ex_ready[i]) begin
        main_d[i]       = skid_q[i];
        skid_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign is_ex_packet = main_q;

endmodule

// File: tb/tb_issue_pipe.sv
// Randomized bench for issue_pipe, compared against a per-lane two-deep FIFO model.
module tb_issue_pipe;
  import issue_pipe_pkg::*;

  localparam int IW = 2;
  localparam int CW = 2;

  logic                         clock = 1'b0;
  logic                         reset = 1'b0;
  ID_IS_PACKET [IW-1:0]         id_is_packet = '0;
  logic [IW-1:0]                is_ready;
  logic [IW-1:0][PREG_W-1:0]    rs1_preg_idx, rs2_preg_idx;
  logic [IW-1:0][XLEN-1:0]      rs1_preg_data, rs2_preg_data;
  logic [CW-1:0]                cdb_valid = '0;
  logic [CW-1:0][PREG_W-1:0]    cdb_preg_idx = '0;
  logic [CW-1:0][XLEN-1:0]      cdb_value = '0;
  logic                         squash = 1'b0;
  logic [IW-1:0]                ex_ready = '0;
  IS_EX_PACKET [IW-1:0]         is_ex_packet;

  issue_pipe #(.ISSUE_WIDTH(IW), .CDB_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .id_is_packet(id_is_packet), .is_ready(is_ready),
    .rs1_preg_idx(rs1_preg_idx), .rs2_preg_idx(rs2_preg_idx),
    .rs1_preg_data(rs1_preg_data), .rs2_preg_data(rs2_preg_data),
    .cdb_valid(cdb_valid), .cdb_preg_idx(cdb_preg_idx), .cdb_value(cdb_value),
    .squash(squash), .ex_ready(ex_ready), .is_ex_packet(is_ex_packet)
  );

  always #5 clock = ~clock;

  logic [XLEN-1:0] rf [64];
  always_comb begin
    for (int i = 0; i < IW; i++) begin
      rs1_preg_data[i] = rf[rs1_preg_idx[i]];
      rs2_preg_data[i] = rf[rs2_preg_idx[i]];
    end
  end

  int checks = 0;
  int failures = 0;
  IS_EX_PACKET mpkt [IW][2];
  int          mcnt [IW];

  function automatic ID_IS_PACKET rand_pkt(input logic v);
    ID_IS_PACKET p;
    p.valid = v;
    p.inst = $urandom();
    p.PC = $urandom();
    p.NPC = $urandom();
    p.opa_select = 2'($urandom());
    p.opb_select = 2'($urandom());
    p.alu_func = 5'($urandom());
    {p.rd_mem, p.wr_mem, p.cond_branch, p.uncond_branch, p.halt, p.illegal, p.csr_op} = 7'($urandom());
    p.function_type = 3'($urandom());
    p.rob_index = 5'($urandom());
    p.has_dest = 1'($urandom());
    p.issued_fu_index = 2'($urandom());
    p.src1_reg.reg_num = PREG_W'($urandom_range(0, 7));
    p.src2_reg.reg_num = PREG_W'($urandom_range(0, 7));
    p.dest_reg.reg_num = PREG_W'($urandom());
    return p;
  endfunction

  function automatic logic [XLEN-1:0] tb_operand(input logic [PREG_W-1:0] idx);
    for (int c = 0; c < CW; c++)
      if (cdb_valid[c] && cdb_preg_idx[c] == idx) return cdb_value[c];
    return rf[idx];
  endfunction

  function automatic IS_EX_PACKET model_capture(input ID_IS_PACKET in);
    IS_EX_PACKET e;
    e = '0;
    e.valid = 1'b1;
    e.inst = in.inst; e.PC = in.PC; e.NPC = in.NPC;
    e.opa_select = in.opa_select; e.opb_select = in.opb_select; e.alu_func = in.alu_func;
    e.rd_mem = in.rd_mem; e.wr_mem = in.wr_mem; e.cond_branch = in.cond_branch;
    e.uncond_branch = in.uncond_branch; e.halt = in.halt; e.illegal = in.illegal;
    e.csr_op = in.csr_op; e.function_type = in.function_type; e.rob_index = in.rob_index;
    e.has_dest = in.has_dest; e.issued_fu_index = in.issued_fu_index;
    e.dest_reg_idx = in.dest_reg.reg_num;
    e.rs1_value = tb_operand(in.src1_reg.reg_num);
    e.rs2_value = tb_operand(in.src2_reg.reg_num);
    return e;
  endfunction

  // Advance one clock with the currently driven inputs; model is a FIFO of depth 2 per lane.
  task automatic step();
    IS_EX_PACKET cap [IW];
    logic        acc [IW];
    for (int i = 0; i < IW; i++) begin
      acc[i] = id_is_packet[i].valid && (mcnt[i] < 2) && !squash;
      cap[i] = model_capture(id_is_packet[i]);
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < IW; i++) begin
      if (squash) mcnt[i] = 0;
      else begin
        if (ex_ready[i] && mcnt[i] > 0) begin
          mpkt[i][0] = mpkt[i][1];
          mcnt[i]--;
        end
        if (acc[i]) begin
          mpkt[i][mcnt[i]] = cap[i];
          mcnt[i]++;
        end
      end
    end
    for (int c = CW - 1; c >= 0; c--)
      if (cdb_valid[c]) rf[cdb_preg_idx[c]] = cdb_value[c];
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < IW; i++) id_is_packet[i] = rand_pkt(1'b0);
    cdb_valid = '0;
    squash = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    ex_ready = '1;
    step();
    step();
    step();
  endtask

  task automatic test_reset();
    for (int r = 0; r < 64; r++) rf[r] = $urandom();
    for (int i = 0; i < IW; i++) mcnt[i] = 0;
    idle_inputs();
    #12;
    for (int i = 0; i < IW; i++) begin
      checks++;
      if (is_ready[i] !== 1'b1) begin
        failures++; $display("FAIL reset_ready lane%0d got=%b want=1", i, is_ready[i]);
      end
      checks++;
      if (is_ex_packet[i] !== '0) begin
        failures++; $display("FAIL reset_pkt lane%0d got=%h want=0", i, is_ex_packet[i]);
      end
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    ID_IS_PACKET p;
    idle_inputs();
    ex_ready = '1;
    rf[5] = 32'h11; rf[6] = 32'h22;
    p = rand_pkt(1'b1);
    p.src1_reg.reg_num = 5; p.src2_reg.reg_num = 6;
    id_is_packet[0] = p;
    #1;
    checks++;
    if (rs1_preg_idx[0] !== PREG_W'(5) || rs2_preg_idx[0] !== PREG_W'(6)) begin
      failures++; $display("FAIL preg_idx got=%0d/%0d want=5/6", rs1_preg_idx[0], rs2_preg_idx[0]);
    end
    step();
    checks++;
    if (is_ex_packet[0].valid !== 1'b1 || is_ex_packet[0].rs1_value !== 32'h11 ||
        is_ex_packet[0].rs2_value !== 32'h22 || is_ex_packet[0].dest_reg_idx !== p.dest_reg.reg_num) begin
      failures++; $display("FAIL basic_issue got v=%b rs1=%h rs2=%h dst=%0d want v=1 rs1=11 rs2=22 dst=%0d",
        is_ex_packet[0].valid, is_ex_packet[0].rs1_value, is_ex_packet[0].rs2_value,
        is_ex_packet[0].dest_reg_idx, p.dest_reg.reg_num);
    end
    for (int k = 0; k < 8; k++) begin
      p = rand_pkt(1'b1);
      id_is_packet[0] = p;
      step();
      checks++;
      if (is_ex_packet[0].valid !== 1'b1 || is_ex_packet[0].inst !== p.inst) begin
        failures++; $display("FAIL b2b_%0d got v=%b inst=%h want v=1 inst=%h", k,
          is_ex_packet[0].valid, is_ex_packet[0].inst, p.inst);
      end
      checks++;
      if (is_ex_packet[0] !== mpkt[0][0]) begin
        failures++; $display("FAIL b2b_model_%0d got=%h want=%h", k, is_ex_packet[0], mpkt[0][0]);
      end
    end
    drain();
  endtask

  task automatic test_bypass();
    ID_IS_PACKET p;
    idle_inputs();
    ex_ready = '1;
    rf[5] = 32'h11; rf[9] = 32'h99;
    p = rand_pkt(1'b1);
    p.src1_reg.reg_num = 5; p.src2_reg.reg_num = 9;
    id_is_packet[0] = p;
    cdb_valid = 2'b10; cdb_preg_idx[1] = 5; cdb_value[1] = 32'hAA; cdb_preg_idx[0] = 3;
    step();
    checks++;
    if (is_ex_packet[0].rs1_value !== 32'hAA || is_ex_packet[0].rs2_value !== 32'h99) begin
      failures++; $display("FAIL bypass_cdb1 got=%h/%h want=aa/99",
        is_ex_packet[0].rs1_value, is_ex_packet[0].rs2_value);
    end
    rf[5] = 32'h11;
    cdb_valid = 2'b11; cdb_preg_idx[0] = 5; cdb_value[0] = 32'hBB; cdb_preg_idx[1] = 5; cdb_value[1] = 32'hAA;
    p = rand_pkt(1'b1);
    p.src1_reg.reg_num = 5; p.src2_reg.reg_num = 5;
    id_is_packet[0] = p;
    step();
    checks++;
    if (is_ex_packet[0].rs1_value !== 32'hBB || is_ex_packet[0].rs2_value !== 32'hBB) begin
      failures++; $display("FAIL bypass_priority got=%h/%h want=bb/bb",
        is_ex_packet[0].rs1_value, is_ex_packet[0].rs2_value);
    end
    drain();
  endtask

  task automatic test_backpressure();
    ID_IS_PACKET a, b, c;
    logic [31:0] want_inst [5];
    logic        want_rdy  [5];
    a = rand_pkt(1'b1); b = rand_pkt(1'b1); c = rand_pkt(1'b1);
    want_inst = '{a.inst, a.inst, a.inst, b.inst, c.inst};
    want_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    idle_inputs();
    ex_ready[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      id_is_packet[0] = (k == 0) ? a : (k == 1) ? b : c;
      if (k >= 3) ex_ready[0] = 1'b1;
      step();
      checks++;
      if (is_ex_packet[0].valid !== 1'b1 || is_ex_packet[0].inst !== want_inst[k] ||
          is_ready[0] !== want_rdy[k]) begin
        failures++; $display("FAIL backpressure_%0d got v=%b inst=%h rdy=%b want v=1 inst=%h rdy=%b",
          k, is_ex_packet[0].valid, is_ex_packet[0].inst, is_ready[0], want_inst[k], want_rdy[k]);
      end
    end
    idle_inputs();
    step();
    checks++;
    if (is_ex_packet[0].valid !== 1'b0) begin
      failures++; $display("FAIL backpressure_tail got v=%b want 0 (C duplicated)", is_ex_packet[0].valid);
    end
    drain();
  endtask

  task automatic test_lane_indep();
    ID_IS_PACKET p1;
    idle_inputs();
    ex_ready = 2'b10;
    for (int k = 0; k < 6; k++) begin
      id_is_packet[0] = rand_pkt(1'b1);
      p1 = rand_pkt(1'b1);
      id_is_packet[1] = p1;
      step();
      checks++;
      if (is_ex_packet[1].valid !== 1'b1 || is_ex_packet[1].inst !== p1.inst) begin
        failures++; $display("FAIL lane1_stream_%0d got v=%b inst=%h want v=1 inst=%h", k,
          is_ex_packet[1].valid, is_ex_packet[1].inst, p1.inst);
      end
      checks++;
      if (is_ready[0] !== (k == 0) || is_ready[1] !== 1'b1) begin
        failures++; $display("FAIL lane_ready_%0d got=%b%b want=1%b", k, is_ready[1], is_ready[0], k == 0);
      end
    end
    drain();
  endtask

  task automatic test_squash();
    idle_inputs();
    ex_ready = '0;
    id_is_packet[0] = rand_pkt(1'b1);
    step();
    id_is_packet[0] = rand_pkt(1'b1);
    step();
    id_is_packet[0] = rand_pkt(1'b1);
    id_is_packet[1] = rand_pkt(1'b1);
    squash = 1'b1;
    step();
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < IW; i++) begin
        checks++;
        if (is_ex_packet[i].valid !== 1'b0 || is_ready[i] !== 1'b1) begin
          failures++; $display("FAIL squash_%0d lane%0d got v=%b rdy=%b want v=0 rdy=1", n, i,
            is_ex_packet[i].valid, is_ready[i]);
        end
      end
      idle_inputs();
      ex_ready = '1;
      step();
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    ex_ready = '0;
    for (int k = 0; k < 2; k++) begin
      id_is_packet[0] = rand_pkt(1'b1);
      id_is_packet[1] = rand_pkt(1'b1);
      step();
    end
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < IW; i++) begin
      mcnt[i] = 0;
      checks++;
      if (is_ex_packet[i] !== '0 || is_ready[i] !== 1'b1) begin
        failures++; $display("FAIL async_reset lane%0d got pkt=%h rdy=%b want 0/1", i, is_ex_packet[i], is_ready[i]);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    ex_ready = '1;
    id_is_packet[0] = rand_pkt(1'b1);
    step();
    checks++;
    if (is_ex_packet[0].valid !== 1'b1 || is_ex_packet[0] !== mpkt[0][0]) begin
      failures++; $display("FAIL post_reset_issue got=%h want=%h", is_ex_packet[0], mpkt[0][0]);
    end
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < IW; i++) id_is_packet[i] = rand_pkt($urandom_range(0, 9) < 7);
      ex_ready = IW'($urandom());
      cdb_valid = CW'($urandom());
      for (int c = 0; c < CW; c++) begin
        cdb_preg_idx[c] = PREG_W'($urandom_range(0, 7));
        cdb_value[c] = $urandom();
      end
      squash = ($urandom_range(0, 19) == 0);
      step();
      for (int i = 0; i < IW; i++) begin
        checks++;
        if (is_ready[i] !== (mcnt[i] < 2) || is_ex_packet[i].valid !== (mcnt[i] > 0)) begin
          failures++; $display("FAIL rand_ctrl_%0d lane%0d got rdy=%b v=%b want rdy=%b v=%b", k, i,
            is_ready[i], is_ex_packet[i].valid, mcnt[i] < 2, mcnt[i] > 0);
        end
        if (mcnt[i] > 0) begin
          checks++;
          if (is_ex_packet[i] !== mpkt[i][0]) begin
            failures++; $display("FAIL rand_pkt_%0d lane%0d got=%h want=%h", k, i, is_ex_packet[i], mpkt[i][0]);
          end
        end
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_backpressure();
    test_lane_indep();
    test_squash();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
